// File: rtl/ir_dir_controller_if.sv
// Bundles the frame/tick inputs and direction/status outputs of the IR direction controller.
interface ir_dir_controller_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          frame_valid;
    logic [31:0]   frame_word;
    logic          tick;
    logic [1:0]    dir;
    logic          dir_changed;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [7:0]    err_count;

    modport master (
        output frame_valid, frame_word, tick,
        input  dir, dir_changed, fifo_count, overflow, err_count
    );

    modport slave (
        input  frame_valid, frame_word, tick,
        output dir, dir_changed, fifo_count, overflow, err_count
    );
endinterface

// File: rtl/ir_dir_controller.sv
// Validates NEC frames, filters reversals/duplicates, queues directions and releases one per game tick.
module ir_dir_controller #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] ADDR      = 8'h20,
    parameter logic [7:0] CMD_UP    = 8'h6A,
    parameter logic [7:0] CMD_DOWN  = 8'hEA,
    parameter logic [7:0] CMD_LEFT  = 8'h1A,
    parameter logic [7:0] CMD_RIGHT = 8'h9A
) (
    input logic nec_clk,
    input logic reset_n,
    ir_dir_controller_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, CHECK, FILTER} state_t;

    state_t        state;
    logic [31:0]   word;
    logic [1:0]    new_dir;
    logic [1:0]    last_dir;
    logic [1:0]    dir_q;
    logic          dir_changed_q;
    logic          overflow_q;
    logic [7:0]    err_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    mem [DEPTH];

    logic [7:0] addr_b, addr_n, cmd_b, cmd_n;
    logic       cmd_known;
    logic [1:0] cmd_dir;
    logic       frame_ok;
    logic       full, pop, accept, push, drop_full, reversal;
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_next;

    assign addr_b = word[31:24];
    assign addr_n = word[23:16];
    assign cmd_b  = word[15:8];
    assign cmd_n  = word[7:0];

    always_comb begin
        cmd_known = 1'b1;
        cmd_dir   = 2'b00;
        case (cmd_b)
            CMD_UP:    cmd_dir = 2'b00;
            CMD_DOWN:  cmd_dir = 2'b01;
            CMD_LEFT:  cmd_dir = 2'b10;
            CMD_RIGHT: cmd_dir = 2'b11;
            default:   cmd_known = 1'b0;
        endcase
    end

    assign frame_ok = (addr_b == ADDR) && (addr_n == ~addr_b) && (cmd_n == ~cmd_b) && cmd_known;

    // Opposite directions differ only in bit 0 with this encoding.
    assign reversal  = (state == FILTER) && (new_dir == (last_dir ^ 2'b01));
    assign accept    = (state == FILTER) && (new_dir != last_dir) && !reversal;
    assign full      = (count == CW'(DEPTH));
    assign push      = accept && !full;
    assign drop_full = accept && full;
    assign pop       = bus.tick && (count != '0);

    // A frame rejected in CHECK and a frame ignored while busy can coincide, so up to two errors per cycle.
    assign err_inc  = 2'({1'b0, (state == CHECK) && !frame_ok})
                    + 2'({1'b0, reversal})
                    + 2'({1'b0, bus.frame_valid && (state != IDLE)});
    assign err_sum  = {1'b0, err_q} + 9'(err_inc);
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge nec_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            word          <= '0;
            new_dir       <= 2'b00;
            last_dir      <= 2'b00;
            dir_q         <= 2'b00;
            dir_changed_q <= 1'b0;
            overflow_q    <= 1'b0;
            err_q         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        word  <= bus.frame_word;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        new_dir <= cmd_dir;
                        state   <= FILTER;
                    end else begin
                        state <= IDLE;
                    end
                end
                FILTER:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                last_dir <= new_dir;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                dir_q  <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            dir_changed_q <= pop;
            overflow_q    <= drop_full;
            err_q         <= err_next;
        end
    end

    always_ff @(posedge nec_clk) begin
        if (push) begin
            mem[wr_ptr] <= new_dir;
        end
    end

    assign bus.dir         = dir_q;
    assign bus.dir_changed = dir_changed_q;
    assign bus.fifo_count  = count;
    assign bus.overflow    = overflow_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_ir_dir_controller.sv
// Directed bench for ir_dir_controller: a queue-based behavioural model checked every cycle plus literal expectations.
module tb_ir_dir_controller;
    localparam int DEPTH = 4;

    localparam logic [31:0] F_UP    = 32'h20DF6A95;
    localparam logic [31:0] F_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] F_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] F_RIGHT = 32'h20DF9A65;
    localparam logic [31:0] F_BADN  = 32'h20DE6A95;
    localparam logic [31:0] F_BADA  = 32'h21DE6A95;

    logic nec_clk = 1'b0;
    logic reset_n;
    bit   checking = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    ir_dir_controller_if #(.DEPTH(DEPTH)) bus ();

    ir_dir_controller #(.DEPTH(DEPTH)) dut (
        .nec_clk (nec_clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 nec_clk = ~nec_clk;

    // Model state: queue of pending directions and the age of the frame in flight (0 = none).
    int          m_dir, m_last, m_err, m_age, m_pend;
    bit          m_chg, m_ovf;
    logic [31:0] m_word;
    int          m_q[$];
    int          inc, nxt_age, d;
    bit          do_push, do_pop, new_ovf;

    function automatic int decode(input logic [31:0] w);
        if (w[31:24] != 8'h20) return -1;
        if ((w[31:24] ^ w[23:16]) != 8'hFF) return -1;
        if ((w[15:8] ^ w[7:0]) != 8'hFF) return -1;
        case (w[15:8])
            8'h6A:   return 0;
            8'hEA:   return 1;
            8'h1A:   return 2;
            8'h9A:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int opposite(input int x);
        case (x)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    always @(posedge nec_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dir = 0; m_last = 0; m_err = 0; m_age = 0; m_pend = 0;
            m_chg = 0; m_ovf = 0; m_word = '0;
            m_q.delete();
        end else begin
            inc = 0; nxt_age = 0; do_push = 0; new_ovf = 0;
            do_pop = bus.tick && (m_q.size() > 0);
            if (m_age == 1) begin
                d = decode(m_word);
                if (d < 0) inc++;
                else begin
                    m_pend  = d;
                    nxt_age = 2;
                end
            end else if (m_age == 2) begin
                if (m_pend == m_last) begin
                end else if (m_pend == opposite(m_last)) inc++;
                else if (m_q.size() == DEPTH) new_ovf = 1;
                else do_push = 1;
            end
            if (bus.frame_valid) begin
                if (m_age == 0) begin
                    m_word  = bus.frame_word;
                    nxt_age = 1;
                end else inc++;
            end
            m_chg = do_pop;
            if (do_pop) m_dir = m_q.pop_front();
            if (do_push) begin
                m_q.push_back(m_pend);
                m_last = m_pend;
            end
            m_ovf = new_ovf;
            m_err = (m_err + inc > 255) ? 255 : m_err + inc;
            m_age = nxt_age;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge nec_clk) begin
        if (checking) begin
            check_output("model_dir", int'(bus.dir), m_dir);
            check_output("model_dir_changed", int'(bus.dir_changed), int'(m_chg));
            check_output("model_fifo_count", int'(bus.fifo_count), m_q.size());
            check_output("model_overflow", int'(bus.overflow), int'(m_ovf));
            check_output("model_err_count", int'(bus.err_count), m_err);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge nec_clk);
    endtask

    task automatic do_reset();
        @(posedge nec_clk);
        #2 reset_n = 1'b0;
        @(posedge nec_clk);
        #2 reset_n = 1'b1;
        @(negedge nec_clk);
    endtask

    task automatic send_frame(input logic [31:0] w);
        @(negedge nec_clk);
        bus.frame_valid = 1'b1;
        bus.frame_word  = w;
        @(negedge nec_clk);
        bus.frame_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge nec_clk);
        bus.tick = 1'b1;
        @(negedge nec_clk);
        bus.tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] seq [5];
        int          exp_dir [5];
        bit          exp_chg [5];

        reset_n         = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_word  = '0;
        bus.tick        = 1'b0;
        do_reset();
        checking = 1'b1;

        check_output("reset_dir", int'(bus.dir), 0);
        check_output("reset_count", int'(bus.fifo_count), 0);
        check_output("reset_err", int'(bus.err_count), 0);

        send_frame(F_RIGHT);
        check_output("latency_n1", int'(bus.fifo_count), 0);
        wait_cycles(1);
        check_output("latency_n2_pre", int'(bus.fifo_count), 0);
        wait_cycles(1);
        check_output("latency_push", int'(bus.fifo_count), 1);
        pulse_tick();
        check_output("tick_dir", int'(bus.dir), 3);
        check_output("tick_pulse", int'(bus.dir_changed), 1);
        check_output("tick_count", int'(bus.fifo_count), 0);
        wait_cycles(1);
        check_output("tick_pulse_end", int'(bus.dir_changed), 0);

        do_reset();
        send_frame(F_DOWN);
        wait_cycles(2);
        check_output("reversal_err", int'(bus.err_count), 1);
        check_output("reversal_count", int'(bus.fifo_count), 0);
        check_output("reversal_dir", int'(bus.dir), 0);

        do_reset();
        send_frame(F_BADN);
        wait_cycles(2);
        send_frame(F_BADA);
        wait_cycles(2);
        check_output("corrupt_err", int'(bus.err_count), 2);
        check_output("corrupt_count", int'(bus.fifo_count), 0);

        do_reset();
        seq = '{F_RIGHT, F_UP, F_LEFT, F_UP, F_RIGHT};
        foreach (seq[i]) begin
            send_frame(seq[i]);
            wait_cycles(2);
        end
        check_output("full_count", int'(bus.fifo_count), 4);
        check_output("overflow_pulse", int'(bus.overflow), 1);
        wait_cycles(1);
        check_output("overflow_end", int'(bus.overflow), 0);
        exp_dir = '{3, 0, 2, 0, 0};
        exp_chg = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            check_output($sformatf("drain_dir_%0d", i), int'(bus.dir), exp_dir[i]);
            check_output($sformatf("drain_pulse_%0d", i), int'(bus.dir_changed), int'(exp_chg[i]));
        end

        do_reset();
        @(negedge nec_clk);
        bus.frame_valid = 1'b1;
        bus.frame_word  = F_LEFT;
        @(negedge nec_clk);
        bus.frame_word  = F_UP;
        @(negedge nec_clk);
        bus.frame_valid = 1'b0;
        wait_cycles(1);
        check_output("busy_count", int'(bus.fifo_count), 1);
        check_output("busy_err", int'(bus.err_count), 1);
        @(negedge nec_clk);
        bus.frame_valid = 1'b1;
        bus.frame_word  = F_UP;
        @(negedge nec_clk);
        bus.frame_valid = 1'b0;
        @(negedge nec_clk);
        bus.tick = 1'b1;
        @(negedge nec_clk);
        bus.tick = 1'b0;
        check_output("pushpop_count", int'(bus.fifo_count), 1);
        check_output("pushpop_dir", int'(bus.dir), 2);
        check_output("pushpop_pulse", int'(bus.dir_changed), 1);

        do_reset();
        send_frame(F_LEFT);
        wait_cycles(2);
        pulse_tick();
        check_output("pre_reset_dir", int'(bus.dir), 2);
        send_frame(F_UP);
        wait_cycles(2);
        send_frame(F_RIGHT);
        wait_cycles(2);
        send_frame(F_DOWN);
        wait_cycles(2);
        check_output("pre_reset_count", int'(bus.fifo_count), 3);
        send_frame(F_UP);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_reset_dir", int'(bus.dir), 0);
        check_output("async_reset_count", int'(bus.fifo_count), 0);
        @(posedge nec_clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            send_frame(F_BADA);
            wait_cycles(1);
        end
        wait_cycles(1);
        check_output("err_saturate", int'(bus.err_count), 255);

        wait_cycles(2);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ir_dir_controller.md
Name: ir_dir_controller

Overview:
- Sits between the NEC IR frame receiver and the snake game core.
- Validates each received 32-bit NEC frame and maps it to a direction command.
- Rejects reversals and duplicates, and buffers accepted commands in a small FIFO.
- Releases one command per game tick, so rapid button presses are applied on successive moves instead of being lost.

Parameters:
- DEPTH, 4: FIFO depth in commands (power of 2, 2..16).
- ADDR, 8'h20: expected NEC address byte.
- CMD_UP, 8'h6A: NEC command byte for up.
- CMD_DOWN, 8'hEA: NEC command byte for down.
- CMD_LEFT, 8'h1A: NEC command byte for left.
- CMD_RIGHT, 8'h9A: NEC command byte for right.

Ports:
- nec_clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  one-cycle pulse; frame_word is valid in that cycle.
- frame_word  in  32  NEC frame, MSB first: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- tick  in  1  one-cycle game-step strobe; requests one queued command.
- dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right.
- dir_changed  out  1  one-cycle pulse in the cycle after dir updates.
- fifo_count  out  $clog2(DEPTH+1)  number of queued commands.
- overflow  out  1  one-cycle pulse when a valid command is dropped because the FIFO is full.
- err_count  out  8  saturating count of rejected or ignored frames.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n); all state is in nec_clk domain.
- Reset values: dir=00 (up), last_dir=00, dir_changed=0, fifo_count=0, overflow=0, err_count=0, FSM=IDLE.
- Reset mid-operation: discards FIFO contents and any in-flight frame.
- FSM states: IDLE, CHECK, FILTER.
  - IDLE: on frame_valid, latch frame_word and go to CHECK.
  - CHECK (1 cycle): validity = (addr==ADDR) & (byte2==~addr) & (byte0==~cmd) & (cmd matches one CMD_*).
    - Invalid: err_count+1, go to IDLE.
    - Valid: register mapped direction, go to FILTER.
  - FILTER (1 cycle): compare against last_dir (the direction of the most recent accepted command; equals the FIFO tail, or dir when the FIFO is empty).
    - Same as last_dir: drop silently, no error.
    - Opposite of last_dir (up/down, left/right): drop, err_count+1.
    - Otherwise, FIFO not full: push, last_dir <= new direction.
    - Otherwise, FIFO full: drop, overflow pulse, last_dir unchanged.
    - Always return to IDLE.
- Frame latency: frame_valid in cycle N -> push visible in fifo_count at end of cycle N+2.
- frame_valid while FSM not in IDLE: frame ignored, err_count+1.
- Tick handling:
  - tick with FIFO non-empty: pop head, dir <= head; dir_changed=1 next cycle.
  - tick with FIFO empty: no change, no pulse.
  - tick while FSM busy: serviced normally; the FSM and the pop path are independent.
- Push and pop in the same cycle: both occur, fifo_count unchanged.
- A full FIFO with a simultaneous pop still counts as full; the push is dropped with an overflow pulse. This is intentionally simple and documented.
- err_count saturates at 8'hFF; it never wraps.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; fifo_count = DEPTH only when full.

Test Plan:
- Reset, then frame 32'h20DF9A65 (right), then tick -> fifo_count 1 at N+2; after tick dir=11, dir_changed single pulse, fifo_count 0.
- Frame 32'h20DFEA15 (down) straight after reset (dir up) -> rejected as reversal, err_count=1, fifo_count 0, dir stays 00.
- Corrupt frames 32'h20DE6A95 (bad ~addr) and 32'h21DE6A95 (wrong addr) -> err_count=2, no push.
- DEPTH=4, no ticks: frames right, up, left, up, right -> first four queued (fifo_count 4); fifth dropped with overflow pulse. Then five ticks -> dir sequence 11, 00, 10, 00, fifth tick no change.
- Frame pulses on consecutive cycles -> second ignored, err_count+1; push and tick in the same cycle -> fifo_count unchanged, dir updated.
- Assert reset_n low with 3 queued commands while in CHECK -> immediately dir=00, fifo_count=0; 300 invalid frames -> err_count stays at 255.
